// File: rtl/channel_pkg.sv
// Purpose: shared state type and constants for the program output channel checker.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package channel_pkg;

   // Checker phases: load expected list, stream compare, drain pipeline, report.
   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } checker_state_t;

   localparam int DefaultMemoryElementWidth = 12;

   // Reported first-mismatch index when every compared word matched.
   localparam logic [15:0] NoMismatch = 16'hFFFF;

endpackage

// File: rtl/channel_fifo.sv
// Purpose: small circular buffer between the output channel and the compare stage.
// Latency: a pushed word is visible at pop_data one cycle after the push edge.
// Backpressure: a push is taken when not full, or when full and popping in the same cycle.
module channel_fifo #(
   parameter int Width = 12,
   parameter int Depth = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic [Width-1:0]             push_data,
   input  logic                         pop,
   output logic [Width-1:0]             pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(Depth+1)-1:0]   count
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CntW'(Depth));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Storage needs no reset; only pointers and count define what is valid.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointer wrap at Depth and occupancy tracking.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/out_channel_checker.sv
// Purpose: streams program output words and checks them in order against a preloaded list.
// Latency: word accepted at edge t is popped at t+1 and counted in received at t+2.
// Backpressure: outReady only in RUN and while the input buffer has room; sustains one word per cycle.
module out_channel_checker
   import channel_pkg::*;
#(
   parameter int MemoryElementWidth = DefaultMemoryElementWidth,
   parameter int NExpect            = 64,
   parameter int NFifo              = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          loadValid,
   input  logic [MemoryElementWidth-1:0] loadData,
   input  logic                          start,
   input  logic                          outValid,
   input  logic [MemoryElementWidth-1:0] outData,
   output logic                          outReady,
   input  logic                          programFinished,
   output logic                          finished,
   output logic                          success,
   output logic [15:0]                   received,
   output logic [15:0]                   firstMismatch
);

   localparam int LcW  = $clog2(NExpect + 1);
   localparam int IdxW = (NExpect > 1) ? $clog2(NExpect) : 1;
   localparam int CntW = $clog2(NFifo + 1);

   checker_state_t                state;
   logic [MemoryElementWidth-1:0] expected [NExpect];
   logic [LcW-1:0]                load_count;
   logic                          overflow;
   logic                          mismatch;

   logic                          fifo_push;
   logic                          fifo_pop;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [CntW-1:0]               fifo_count;
   logic [MemoryElementWidth-1:0] fifo_data;

   logic                          cmp_valid;
   logic [MemoryElementWidth-1:0] cmp_data;
   logic [MemoryElementWidth-1:0] exp_word;
   logic                          in_range;
   logic                          word_bad;
   logic                          drain_empty;

   assign outReady    = (state == RUN) && !fifo_full;
   assign fifo_push   = outValid && outReady;
   assign fifo_pop    = !fifo_empty && ((state == RUN) || (state == DRAIN));
   assign drain_empty = (fifo_count == '0) && !cmp_valid;

   // A word beyond the loaded list is a mismatch; the memory is only read when in range.
   assign in_range = (received < 16'(load_count));
   assign exp_word = expected[received[IdxW-1:0]];
   assign word_bad = !in_range || (cmp_data != exp_word);

   channel_fifo #(
      .Width(MemoryElementWidth),
      .Depth(NFifo)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (outData),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Capture the expected list; writes past capacity are dropped and flagged.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         load_count <= '0;
         overflow   <= 1'b0;
         for (int i = 0; i < NExpect; i++) expected[i] <= '0;
      end else if ((state == LOAD) && loadValid) begin
         if (load_count == LcW'(NExpect)) begin
            overflow <= 1'b1;
         end else begin
            expected[load_count[IdxW-1:0]] <= loadData;
            load_count                     <= load_count + LcW'(1);
         end
      end
   end

   // Pop into the compare register, then score it against expected[received] the next cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cmp_valid     <= 1'b0;
         cmp_data      <= '0;
         received      <= '0;
         firstMismatch <= NoMismatch;
         mismatch      <= 1'b0;
      end else begin
         cmp_valid <= fifo_pop;
         if (fifo_pop) cmp_data <= fifo_data;
         if (cmp_valid) begin
            if (received != 16'hFFFF) received <= received + 16'd1;
            if (word_bad && !mismatch) begin
               mismatch      <= 1'b1;
               firstMismatch <= received;
            end
         end
      end
   end

   // Phase sequencing with registered completion flags; DONE is held until reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= LOAD;
         finished <= 1'b0;
         success  <= 1'b0;
      end else begin
         case (state)
            LOAD:  if (start) state <= RUN;
            RUN:   if (programFinished) state <= DRAIN;
            DRAIN: begin
               if (drain_empty) begin
                  state    <= DONE;
                  finished <= 1'b1;
                  success  <= !mismatch && !overflow && (received == 16'(load_count));
               end
            end
            default: state <= state;
         endcase
      end
   end

endmodule

// File: tb/tb_out_channel_checker.sv
// Purpose: randomized and directed bench for out_channel_checker against a queue-based model.
// Latency: model predicts each accepted word is scored two edges after acceptance.
// Backpressure: driver holds each word until outReady is seen.
module tb_out_channel_checker;

   localparam int W  = 12;
   localparam int NE = 8;
   localparam int NF = 4;

   logic          clock           = 1'b0;
   logic          reset           = 1'b0;
   logic          loadValid       = 1'b0;
   logic [W-1:0]  loadData        = '0;
   logic          start           = 1'b0;
   logic          outValid        = 1'b0;
   logic [W-1:0]  outData         = '0;
   logic          outReady;
   logic          programFinished = 1'b0;
   logic          finished;
   logic          success;
   logic [15:0]   received;
   logic [15:0]   firstMismatch;

   int checks      = 0;
   int failures    = 0;
   int ready_drops = 0;

   out_channel_checker #(
      .MemoryElementWidth(W),
      .NExpect(NE),
      .NFifo(NF)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .loadValid       (loadValid),
      .loadData        (loadData),
      .start           (start),
      .outValid        (outValid),
      .outData         (outData),
      .outReady        (outReady),
      .programFinished (programFinished),
      .finished        (finished),
      .success         (success),
      .received        (received),
      .firstMismatch   (firstMismatch)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int P_LOAD  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DRAIN = 2;

   int           m_phase = P_LOAD;
   int           cyc     = 0;
   int           fin_cyc = -1;
   bit           m_ovf   = 1'b0;
   logic [W-1:0] m_exp[$];
   logic [W-1:0] acc_dat[$];
   int           acc_cyc[$];

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_phase = P_LOAD;
         cyc     = 0;
         fin_cyc = -1;
         m_ovf   = 1'b0;
         m_exp.delete();
         acc_dat.delete();
         acc_cyc.delete();
      end else begin
         cyc++;
         if (m_phase == P_LOAD) begin
            if (loadValid) begin
               if (m_exp.size() < NE) m_exp.push_back(loadData);
               else m_ovf = 1'b1;
            end
            if (start) m_phase = P_RUN;
         end else if (m_phase == P_RUN) begin
            if (outValid) begin
               acc_dat.push_back(outData);
               acc_cyc.push_back(cyc);
            end
            if (programFinished) begin
               fin_cyc = cyc + 1;
               if (acc_cyc.size() > 0 && acc_cyc[$] + 3 > fin_cyc) fin_cyc = acc_cyc[$] + 3;
               m_phase = P_DRAIN;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(posedge clock) begin
      int          n;
      logic [15:0] fm;
      bit          bad_any;
      logic        rdy;
      logic        fin;
      logic        suc;
      #1;
      n       = 0;
      fm      = 16'hFFFF;
      bad_any = 1'b0;
      for (int i = 0; i < acc_cyc.size(); i++) begin
         if (acc_cyc[i] + 2 <= cyc) begin
            n++;
            if (i >= m_exp.size() || acc_dat[i] != m_exp[i]) begin
               if (!bad_any) fm = 16'(i);
               bad_any = 1'b1;
            end
         end
      end
      if (n > 65535) n = 65535;
      rdy = reset && (m_phase == P_RUN);
      fin = reset && (fin_cyc >= 0) && (cyc >= fin_cyc);
      suc = fin && !bad_any && !m_ovf && (acc_cyc.size() == m_exp.size());
      chk("cyc_outReady", 32'(outReady), 32'(rdy));
      chk("cyc_received", 32'(received), 32'(n));
      chk("cyc_firstMismatch", 32'(firstMismatch), 32'(fm));
      chk("cyc_finished", 32'(finished), 32'(fin));
      chk("cyc_success", 32'(success), 32'(suc));
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      reset           = 1'b0;
      loadValid       = 1'b0;
      start           = 1'b0;
      outValid        = 1'b0;
      programFinished = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic load_words(input logic [W-1:0] w[$], input bit start_with_last);
      foreach (w[i]) begin
         loadValid = 1'b1;
         loadData  = w[i];
         start     = start_with_last && (i == w.size() - 1);
         @(negedge clock);
      end
      loadValid = 1'b0;
      start     = 1'b0;
      if (!start_with_last || w.size() == 0) begin
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
   endtask

   task automatic stream(input logic [W-1:0] w[$], input int gap_pct,
                         input bit finish_with_last, input bit do_finish);
      int budget;
      foreach (w[i]) begin
         while ($urandom_range(99) < gap_pct) begin
            outValid        = 1'b0;
            programFinished = 1'b0;
            @(negedge clock);
         end
         outValid        = 1'b1;
         outData         = w[i];
         programFinished = do_finish && finish_with_last && (i == w.size() - 1);
         budget          = 20;
         while (!outReady && budget > 0) begin
            ready_drops++;
            @(negedge clock);
            budget--;
         end
         checks++;
         if (!outReady) begin
            failures++;
            $display("FAIL stream_ready_timeout outReady=%0d required=1", outReady);
         end
         @(negedge clock);
      end
      outValid        = 1'b0;
      programFinished = 1'b0;
      if (do_finish && (!finish_with_last || w.size() == 0)) begin
         repeat ($urandom_range(2)) @(negedge clock);
         programFinished = 1'b1;
         @(negedge clock);
         programFinished = 1'b0;
      end
   endtask

   task automatic wait_done(input string name);
      int budget = 40;
      while (!finished && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      checks++;
      if (!finished) begin
         failures++;
         $display("FAIL %s_timeout finished=%0d required=1", name, finished);
      end
   endtask

   task automatic run(input logic [W-1:0] ld[$], input logic [W-1:0] st[$], input bit merge,
                      input int gap, input bit fwl, input string name);
      do_reset();
      load_words(ld, merge);
      stream(st, gap, fwl, 1'b1);
      wait_done(name);
   endtask

   // ---------------- directed then random scenarios ----------------
   initial begin
      logic [W-1:0] ld[$];
      logic [W-1:0] st[$];
      int           len;
      int           k;

      // Single matching word.
      ld = '{12'd2}; st = '{12'd2};
      run(ld, st, 1'b0, 0, 1'b0, "one");
      chk("one_success", 32'(success), 32'd1);
      chk("one_received", 32'(received), 32'd1);
      chk("one_firstMismatch", 32'(firstMismatch), 32'hFFFF);

      // Second word differs.
      ld = '{12'd2, 12'd5}; st = '{12'd2, 12'd6};
      run(ld, st, 1'b0, 0, 1'b0, "diff");
      chk("diff_success", 32'(success), 32'd0);
      chk("diff_firstMismatch", 32'(firstMismatch), 32'd1);
      chk("diff_received", 32'(received), 32'd2);

      // Program stops short of the list.
      ld = '{12'd1, 12'd2, 12'd3}; st = '{12'd1, 12'd2};
      run(ld, st, 1'b0, 0, 1'b0, "short");
      chk("short_received", 32'(received), 32'd2);
      chk("short_success", 32'(success), 32'd0);
      chk("short_firstMismatch", 32'(firstMismatch), 32'hFFFF);

      // Extra word beyond the list.
      ld = '{12'd7}; st = '{12'd7, 12'd7};
      run(ld, st, 1'b0, 0, 1'b0, "extra");
      chk("extra_firstMismatch", 32'(firstMismatch), 32'd1);
      chk("extra_success", 32'(success), 32'd0);

      // Continuous stream, finish on final acceptance.
      ld = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd50, 12'd60};
      st = ld;
      do_reset();
      load_words(ld, 1'b0);
      ready_drops = 0;
      stream(st, 0, 1'b1, 1'b1);
      chk("bp_ready_drops", 32'(ready_drops), 32'd0);
      wait_done("bp");
      chk("bp_success", 32'(success), 32'd1);
      chk("bp_received", 32'(received), 32'd6);

      // Empty expected list with no words.
      ld.delete(); st.delete();
      run(ld, st, 1'b0, 0, 1'b0, "empty");
      chk("empty_success", 32'(success), 32'd1);
      chk("empty_received", 32'(received), 32'd0);

      // One load past capacity fails even though all stored words match.
      ld.delete();
      for (int i = 0; i < NE + 1; i++) ld.push_back(W'(i + 100));
      st = ld[0:NE-1];
      run(ld, st, 1'b0, 0, 1'b0, "ovf");
      chk("ovf_success", 32'(success), 32'd0);
      chk("ovf_received", 32'(received), 32'(NE));
      chk("ovf_firstMismatch", 32'(firstMismatch), 32'hFFFF);

      // Start in the same cycle as the last load.
      ld = '{12'd3, 12'hFFF}; st = '{12'd3, 12'hFFF};
      run(ld, st, 1'b1, 0, 1'b0, "merge");
      chk("merge_success", 32'(success), 32'd1);

      // Reset in RUN after two of three words, then a fresh check.
      ld = '{12'd1, 12'd2, 12'd3}; st = '{12'd1, 12'd2};
      do_reset();
      load_words(ld, 1'b0);
      stream(st, 0, 1'b0, 1'b0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_outReady", 32'(outReady), 32'd0);
      chk("rst_finished", 32'(finished), 32'd0);
      chk("rst_success", 32'(success), 32'd0);
      chk("rst_received", 32'(received), 32'd0);
      chk("rst_firstMismatch", 32'(firstMismatch), 32'hFFFF);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_load_outReady", 32'(outReady), 32'd0);
      ld = '{12'd4}; st = '{12'd4};
      load_words(ld, 1'b0);
      stream(st, 0, 1'b1, 1'b1);
      wait_done("reload");
      chk("reload_success", 32'(success), 32'd1);
      chk("reload_received", 32'(received), 32'd1);

      // Randomized lists, mutations, gaps and finish timing.
      for (int r = 0; r < 30; r++) begin
         len = $urandom_range(0, NE + 2);
         ld.delete();
         for (int i = 0; i < len; i++) ld.push_back(W'($urandom_range(0, 15)));
         st = ld;
         case ($urandom_range(3))
            1: if (st.size() > 0) begin
                  k = $urandom_range(st.size() - 1);
                  st[k] = st[k] ^ 12'h001;
               end
            2: if (st.size() > 0) st.pop_back();
            3: st.push_back(W'($urandom_range(0, 15)));
            default: ;
         endcase
         run(ld, st, 1'($urandom_range(1)), $urandom_range(0, 40), 1'($urandom_range(1)), "rand");
      end

      @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
